// File: rtl/pong_score_pkg.sv
// Shared types and constants for the pong score/lives keeper and its HUD renderer.
package pong_score_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_OVER = 2'd2
   } state_t;

   localparam int DIGIT_W     = 12;
   localparam int DIGIT_H     = 17;
   localparam int DIGIT_PITCH = 16;

   localparam logic [11:0] SCORE_MAX = 12'h999;

   // Saturating 3-digit BCD increment.
   function automatic logic [11:0] bcd_inc(input logic [11:0] v);
      logic [3:0] h;
      logic [3:0] t;
      logic [3:0] u;
      h = v[11:8];
      t = v[7:4];
      u = v[3:0];
      if (v != SCORE_MAX) begin
         if (u == 4'd9) begin
            u = 4'd0;
            if (t == 4'd9) begin
               t = 4'd0;
               h = h + 4'd1;
            end else begin
               t = t + 4'd1;
            end
         end else begin
            u = u + 4'd1;
         end
      end
      return {h, t, u};
   endfunction

endpackage

// File: rtl/pong_score_seg7_decode.sv
// BCD to 7-segment decoder, output ordered {a,b,c,d,e,f,g}; non-decimal codes are blank.
module seg7_decode (
   input  logic [3:0] i_bcd,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = 7'b0000000;
      case (i_bcd)
         4'd0: o_seg = 7'b1111110;
         4'd1: o_seg = 7'b0110000;
         4'd2: o_seg = 7'b1101101;
         4'd3: o_seg = 7'b1111001;
         4'd4: o_seg = 7'b0110011;
         4'd5: o_seg = 7'b1011011;
         4'd6: o_seg = 7'b1011111;
         4'd7: o_seg = 7'b1110000;
         4'd8: o_seg = 7'b1111111;
         4'd9: o_seg = 7'b1111011;
         default: o_seg = 7'b0000000;
      endcase
   end

endmodule

// File: rtl/pong_score.sv
// Score/lives keeper with game FSM and a registered per-pixel score renderer
// drawn from a once-per-frame snapshot of the score.
module pong_score
   import pong_score_pkg::*;
#(
   parameter int DIGIT_X0  = 350,
   parameter int DIGIT_Y0  = 4,
   parameter int MAX_LIVES = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        ponto,
   input  logic        miss,
   input  logic [9:0]  x,
   input  logic [9:0]  y,
   input  logic        activevideo,
   output logic [11:0] score_bcd,
   output logic [1:0]  lives,
   output logic        game_over,
   output logic        freeze,
   output logic        score_pixel
);

   localparam logic [1:0] LIVES_INIT = 2'(MAX_LIVES);
   localparam logic [9:0] X0         = 10'(DIGIT_X0);
   localparam logic [9:0] Y0         = 10'(DIGIT_Y0);

   state_t      r_state;
   logic [11:0] r_score;
   logic [11:0] r_disp;
   logic [1:0]  r_lives;
   logic        r_pixel;
   logic        w_lit;
   logic [2:0]  w_hit;
   logic [2:0]  w_show;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_score <= 12'h000;
         r_disp  <= 12'h000;
         r_lives <= LIVES_INIT;
         r_pixel <= 1'b0;
      end else begin
         r_pixel <= activevideo & w_lit;
         // Frame-start snapshot keeps the HUD from tearing mid-frame.
         if (x == 10'd0 && y == 10'd0) begin
            r_disp <= r_score;
         end
         case (r_state)
            ST_IDLE: begin
               r_score <= 12'h000;
               r_lives <= LIVES_INIT;
               if (start) begin
                  r_state <= ST_PLAY;
               end
            end
            ST_PLAY: begin
               if (!start) begin
                  r_state <= ST_IDLE;
                  r_score <= 12'h000;
                  r_lives <= LIVES_INIT;
               end else begin
                  if (ponto) begin
                     r_score <= bcd_inc(r_score);
                  end
                  if (miss && r_lives != 2'd0) begin
                     r_lives <= r_lives - 2'd1;
                     if (r_lives == 2'd1) begin
                        r_state <= ST_OVER;
                     end
                  end
               end
            end
            ST_OVER: begin
               if (!start) begin
                  r_state <= ST_IDLE;
                  r_score <= 12'h000;
                  r_lives <= LIVES_INIT;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Leading-zero blanking; units always shown.
   assign w_show[0] = (r_disp[11:8] != 4'd0);
   assign w_show[1] = (r_disp[11:4] != 8'd0);
   assign w_show[2] = 1'b1;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_digit
         localparam logic [9:0] XK = X0 + 10'(gi * DIGIT_PITCH);
         logic [6:0] w_seg;
         logic [9:0] w_c;
         logic [9:0] w_r;
         logic       w_in;
         logic [6:0] w_box;

         seg7_decode u_dec (
            .i_bcd (r_disp[11 - 4*gi -: 4]),
            .o_seg (w_seg)
         );

         assign w_c  = x - XK;
         assign w_r  = y - Y0;
         assign w_in = (x >= XK) && (x <= XK + 10'(DIGIT_W - 1)) &&
                       (y >= Y0) && (y <= Y0 + 10'(DIGIT_H - 1));

         assign w_box[6] = (w_r <= 10'd1);
         assign w_box[5] = (w_c >= 10'(DIGIT_W - 2)) && (w_r <= 10'(DIGIT_H / 2));
         assign w_box[4] = (w_c >= 10'(DIGIT_W - 2)) && (w_r >= 10'(DIGIT_H / 2));
         assign w_box[3] = (w_r >= 10'(DIGIT_H - 2));
         assign w_box[2] = (w_c <= 10'd1) && (w_r >= 10'(DIGIT_H / 2));
         assign w_box[1] = (w_c <= 10'd1) && (w_r <= 10'(DIGIT_H / 2));
         assign w_box[0] = (w_r == 10'(DIGIT_H / 2)) || (w_r == 10'(DIGIT_H / 2 + 1));

         assign w_hit[gi] = w_in && w_show[gi] && (|(w_seg & w_box));
      end
   endgenerate

   assign w_lit = |w_hit;

   assign score_bcd   = r_score;
   assign lives       = r_lives;
   assign game_over   = (r_state == ST_OVER);
   assign freeze      = (r_state != ST_PLAY);
   assign score_pixel = r_pixel;

endmodule

// File: tb/tb_pong_score.sv
// Self-checking bench for pong_score: integer-level game model plus a
// letter-table segment renderer, driven by directed steps and $urandom traffic.
module tb_pong_score;

   localparam int X0 = 350;
   localparam int Y0 = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic        ponto;
   logic        miss;
   logic [9:0]  x;
   logic [9:0]  y;
   logic        activevideo;
   logic [11:0] score_bcd;
   logic [1:0]  lives;
   logic        game_over;
   logic        freeze;
   logic        score_pixel;

   int checks   = 0;
   int failures = 0;

   // Model state: mode 0 menu, 1 playing, 2 game over; scores as plain integers.
   int m_state = 0;
   int m_score = 0;
   int m_lives = 3;
   int m_disp  = 0;
   bit m_pix   = 1'b0;

   string seg_tab [0:9] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                            "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

   pong_score #(.DIGIT_X0(X0), .DIGIT_Y0(Y0), .MAX_LIVES(3)) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .ponto       (ponto),
      .miss        (miss),
      .x           (x),
      .y           (y),
      .activevideo (activevideo),
      .score_bcd   (score_bcd),
      .lives       (lives),
      .game_over   (game_over),
      .freeze      (freeze),
      .score_pixel (score_pixel)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] to_bcd(int v);
      return 32'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
   endfunction

   function automatic bit m_lit(int d, int px, int py);
      int    k, c, r, v;
      string s;
      if (px < X0 || py < Y0) return 1'b0;
      k = (px - X0) / 16;
      c = (px - X0) % 16;
      r = py - Y0;
      if (k > 2 || c > 11 || r > 16) return 1'b0;
      if (k == 0 && d < 100) return 1'b0;
      if (k == 1 && d < 10) return 1'b0;
      v = (k == 0) ? d / 100 : (k == 1) ? (d / 10) % 10 : d % 10;
      s = seg_tab[v];
      for (int i = 0; i < s.len(); i++) begin
         if (s[i] == "a" && r <= 1) return 1'b1;
         if (s[i] == "b" && c >= 10 && r <= 8) return 1'b1;
         if (s[i] == "c" && c >= 10 && r >= 8) return 1'b1;
         if (s[i] == "d" && r >= 15) return 1'b1;
         if (s[i] == "e" && c <= 1 && r >= 8) return 1'b1;
         if (s[i] == "f" && c <= 1 && r <= 8) return 1'b1;
         if (s[i] == "g" && (r == 8 || r == 9)) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      if (reset) begin
         m_state = 0; m_score = 0; m_lives = 3; m_disp = 0; m_pix = 1'b0;
      end else begin
         m_pix = activevideo && m_lit(m_disp, int'(x), int'(y));
         if (x == 10'd0 && y == 10'd0) m_disp = m_score;
         case (m_state)
            0: begin
               m_score = 0; m_lives = 3;
               if (start) m_state = 1;
            end
            1: begin
               if (!start) begin
                  m_state = 0; m_score = 0; m_lives = 3;
               end else begin
                  if (ponto && m_score < 999) m_score++;
                  if (miss && m_lives > 0) begin
                     m_lives--;
                     if (m_lives == 0) m_state = 2;
                  end
               end
            end
            default: begin
               if (!start) begin
                  m_state = 0; m_score = 0; m_lives = 3;
               end
            end
         endcase
      end
      @(posedge clock);
      #1;
      chk("score", 32'(score_bcd), to_bcd(m_score));
      chk("lives", 32'(lives), 32'(m_lives));
      chk("game_over", 32'(game_over), 32'(m_state == 2));
      chk("freeze", 32'(freeze), 32'(m_state != 1));
      chk("pixel", 32'(score_pixel), 32'(m_pix));
   endtask

   task automatic pulses(input int n);
      for (int i = 0; i < n; i++) begin
         ponto = 1'b1;
         tick();
         ponto = 1'b0;
         if ($urandom_range(0, 1) == 1) tick();
      end
   endtask

   task automatic snapshot();
      x = 10'd0; y = 10'd0; activevideo = 1'b0;
      tick();
      x = 10'd5; y = 10'd5;
   endtask

   task automatic sweep();
      activevideo = 1'b1;
      for (int yy = Y0 - 1; yy <= Y0 + 17; yy++) begin
         for (int xx = X0 - 1; xx <= X0 + 48; xx++) begin
            x = 10'(xx); y = 10'(yy);
            tick();
         end
      end
      activevideo = 1'b0; x = 10'd5; y = 10'd5;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; ponto = 1'b0; miss = 1'b0;
      x = 10'd5; y = 10'd5; activevideo = 1'b0;
      tick();
      tick();
      chk("rst_score", 32'(score_bcd), 32'h000);
      chk("rst_lives", 32'(lives), 32'd3);
      chk("rst_freeze", 32'(freeze), 32'd1);
      chk("rst_pixel", 32'(score_pixel), 32'd0);

      // Twelve hits from a fresh game.
      reset = 1'b0; start = 1'b1;
      tick();
      pulses(12);
      chk("score_012", 32'(score_bcd), 32'h012);
      chk("lives_3", 32'(lives), 32'd3);
      chk("play_freeze", 32'(freeze), 32'd0);

      // Random traffic over the HUD area with occasional frame starts and menu drops.
      for (int i = 0; i < 600; i++) begin
         ponto = ($urandom_range(0, 2) == 0);
         miss  = ($urandom_range(0, 24) == 0);
         start = ($urandom_range(0, 60) != 0);
         activevideo = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 30) == 0) begin
            x = 10'd0; y = 10'd0;
         end else begin
            x = 10'(X0 - 2 + int'($urandom_range(0, 52)));
            y = 10'($urandom_range(0, 24));
         end
         tick();
      end
      ponto = 1'b0; miss = 1'b0; activevideo = 1'b0; x = 10'd5; y = 10'd5;

      // Saturation at 999.
      reset = 1'b1; tick();
      reset = 1'b0; start = 1'b1; tick();
      ponto = 1'b1;
      repeat (999) tick();
      chk("score_999", 32'(score_bcd), 32'h999);
      tick();
      chk("score_sat", 32'(score_bcd), 32'h999);
      ponto = 1'b0;

      // Three misses end the game.
      for (int i = 0; i < 3; i++) begin
         miss = 1'b1; tick(); miss = 1'b0;
         chk("miss_lives", 32'(lives), 32'(2 - i));
      end
      chk("over_go", 32'(game_over), 32'd1);
      chk("over_freeze", 32'(freeze), 32'd1);
      ponto = 1'b1; tick(); ponto = 1'b0;
      chk("over_hold", 32'(score_bcd), 32'h999);

      // Simultaneous hit and miss at score 8.
      start = 1'b0; tick();
      start = 1'b1; tick();
      pulses(8);
      ponto = 1'b1; miss = 1'b1; tick();
      ponto = 1'b0; miss = 1'b0;
      chk("both_score", 32'(score_bcd), 32'h009);
      chk("both_lives", 32'(lives), 32'd2);

      // Mid-frame change 7 -> 8 only appears after the next frame start.
      start = 1'b0; tick();
      start = 1'b1; tick();
      pulses(7);
      snapshot();
      ponto = 1'b1; tick(); ponto = 1'b0;
      x = 10'(X0 + 37); y = 10'(Y0 + 8); activevideo = 1'b1; tick();
      chk("g_before", 32'(score_pixel), 32'd0);
      snapshot();
      x = 10'(X0 + 37); y = 10'(Y0 + 8); activevideo = 1'b1; tick();
      chk("g_after", 32'(score_pixel), 32'd1);
      x = 10'(X0 + 5); tick();
      chk("hund_blank", 32'(score_pixel), 32'd0);
      x = 10'(X0 + 21); tick();
      chk("tens_blank", 32'(score_pixel), 32'd0);
      activevideo = 1'b0; x = 10'd5; y = 10'd5;
      sweep();

      // Render 45, then reset mid-game.
      pulses(37);
      snapshot();
      sweep();
      chk("score_045", 32'(score_bcd), 32'h045);
      reset = 1'b1; tick();
      chk("mid_rst_score", 32'(score_bcd), 32'h000);
      chk("mid_rst_lives", 32'(lives), 32'd3);
      chk("mid_rst_freeze", 32'(freeze), 32'd1);
      chk("mid_rst_pixel", 32'(score_pixel), 32'd0);
      reset = 1'b0; start = 1'b0; ponto = 1'b1; miss = 1'b1;
      repeat (3) tick();
      ponto = 1'b0; miss = 1'b0;
      chk("idle_score", 32'(score_bcd), 32'h000);
      chk("idle_lives", 32'(lives), 32'd3);

      // A random three-digit score rendered in full.
      start = 1'b1; tick();
      pulses(int'($urandom_range(100, 250)));
      snapshot();
      sweep();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
